// File: rtl/mcm_controller.sv
// Multicycle main controller for the MCU datapath.
// Sequences fetch/decode/execute/memory/writeback over a shared memory and ALU.
// It also holds the NZCV flag register and evaluates condition codes.
// Optional build macro MCM_RETIRE_CNT_EN adds a retired-instruction counter output.
module mcm_controller #(
  parameter int          RET_W     = 32,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] instr_cond,
  input  logic [1:0] instr_op,
  input  logic [5:0] instr_funct,
  input  logic [3:0] instr_rd,
  input  logic [3:0] alu_flags,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       adrsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [1:0] immsrc,
  output logic [1:0] regsrc,
  output logic [1:0] alucontrol,
  output logic [3:0] flags,
  output logic [3:0] state,
  output logic       illegal
`ifdef MCM_RETIRE_CNT_EN
  ,
  output logic [RET_W-1:0] retired
`endif
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q;

  // Strobes before the reset mask is applied.
  logic irwrite_s, pcwrite_s, regwrite_s, memwrite_s, illegal_s;
  logic retire_s;

  logic [3:0] cmd;
  logic       is_cmp;
  logic [1:0] alu_dp;
  logic       cond_ok;
  logic       bad_instr;
  logic       flag_we;

  assign cmd = instr_funct[4:1];

  // Data-processing command to ALU operation; unknown commands fall back to ADD.
  always_comb begin
    is_cmp = (cmd == 4'b1010);
    unique case (cmd)
      4'b0010, 4'b1010: alu_dp = 2'b01;
      4'b0000:          alu_dp = 2'b10;
      4'b1100:          alu_dp = 2'b11;
      default:          alu_dp = 2'b00;
    endcase
  end

  // Condition evaluation against the stored flags, not the live ALU flags.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    unique case (instr_cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = !z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = !c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = !n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = !v;
      4'b1000: cond_ok = c && !z;
      4'b1001: cond_ok = !c || z;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = !z && (n == v);
      4'b1101: cond_ok = z || (n != v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign bad_instr = (instr_op == 2'b11) || (instr_cond == 4'b1111);
  assign flag_we   = ((state_q == EXECR) || (state_q == EXECI)) && (instr_funct[0] || is_cmp);

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every combinational output is given a default first so no latch is inferred.
    state_d    = FETCH;
    irwrite_s  = 1'b0;
    pcwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    illegal_s  = 1'b0;
    retire_s   = 1'b0;
    adrsrc     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    resultsrc  = 2'b00;
    immsrc     = 2'b00;
    regsrc     = 2'b00;
    alucontrol = 2'b00;
    case (state_q)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        state_d   = DECODE;
      end
      DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        illegal_s = bad_instr;
        if (bad_instr || !cond_ok) state_d = FETCH;
        else if (instr_op == 2'b01) state_d = MEMADR;
        else if (instr_op == 2'b10) state_d = BRANCH;
        else state_d = instr_funct[5] ? EXECI : EXECR;
      end
      MEMADR: begin
        alusrcb = 2'b01;
        immsrc  = 2'b01;
        regsrc  = 2'b10;
        state_d = instr_funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adrsrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWR: begin
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
        regsrc     = 2'b10;
        retire_s   = 1'b1;
        state_d    = FETCH;
      end
      MEMWB: begin
        resultsrc  = 2'b01;
        pcwrite_s  = (instr_rd == 4'd15);
        regwrite_s = (instr_rd != 4'd15);
        retire_s   = 1'b1;
        state_d    = FETCH;
      end
      EXECR, EXECI: begin
        alusrcb    = (state_q == EXECI) ? 2'b01 : 2'b00;
        alucontrol = alu_dp;
        retire_s   = is_cmp;
        state_d    = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        pcwrite_s  = (instr_rd == 4'd15);
        regwrite_s = (instr_rd != 4'd15);
        retire_s   = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alusrcb   = 2'b01;
        immsrc    = 2'b10;
        resultsrc = 2'b10;
        regsrc    = 2'b01;
        pcwrite_s = 1'b1;
        retire_s  = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // While reset is held no architectural write may escape.
  assign irwrite  = irwrite_s  & rst;
  assign pcwrite  = pcwrite_s  & rst;
  assign regwrite = regwrite_s & rst;
  assign memwrite = memwrite_s & rst;
  assign illegal  = illegal_s  & rst;
  assign flags    = flags_q;
  assign state    = state_q;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  // NZCV register: logical ops leave C and V untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_q <= FLAGS_RST;
    end else if (flag_we) begin
      flags_q[3:2] <= alu_flags[3:2];
      if (!alu_dp[1]) flags_q[1:0] <= alu_flags[1:0];
    end
  end

`ifdef MCM_RETIRE_CNT_EN
  // Counts completed instructions; condition-failed and illegal ones never retire.
  always_ff @(posedge clk) begin
    if (!rst)          retired <= '0;
    else if (retire_s) retired <= retired + RET_W'(1);
  end
`endif

endmodule

// File: tb/tb_mcm_controller.sv
// Directed testbench for mcm_controller with hand-computed expectations.
// Build with +define+MCM_RETIRE_CNT_EN to also exercise the retired counter.
module tb_mcm_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] instr_cond;
  logic [1:0] instr_op;
  logic [5:0] instr_funct;
  logic [3:0] instr_rd;
  logic [3:0] alu_flags;
  logic       irwrite, pcwrite, regwrite, memwrite, adrsrc, alusrca, illegal;
  logic [1:0] alusrcb, resultsrc, immsrc, regsrc, alucontrol;
  logic [3:0] flags, state;
`ifdef MCM_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int checks   = 0;
  int failures = 0;

  mcm_controller dut (
    .clk        (clk),
    .rst        (rst),
    .instr_cond (instr_cond),
    .instr_op   (instr_op),
    .instr_funct(instr_funct),
    .instr_rd   (instr_rd),
    .alu_flags  (alu_flags),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .adrsrc     (adrsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .immsrc     (immsrc),
    .regsrc     (regsrc),
    .alucontrol (alucontrol),
    .flags      (flags),
    .state      (state),
    .illegal    (illegal)
`ifdef MCM_RETIRE_CNT_EN
    ,
    .retired    (retired)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_ret(input string tag, input int exp);
`ifdef MCM_RETIRE_CNT_EN
    check(tag, retired, exp);
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [3:0] c, input logic [1:0] op,
                        input logic [5:0] f, input logic [3:0] rd);
    instr_cond  = c;
    instr_op    = op;
    instr_funct = f;
    instr_rd    = rd;
  endtask

  initial begin
    rst       = 1'b0;
    alu_flags = 4'b0000;
    set_ir(4'b1110, 2'b00, 6'b101000, 4'd1);
    tick();
    tick();
    check("rst_state", state, 0);
    check("rst_flags", flags, 4'b0000);
    check("rst_irwrite", irwrite, 0);
    check("rst_pcwrite", pcwrite, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_memwrite", memwrite, 0);
    rst = 1'b1;
    #1;
    check("fetch_irwrite", irwrite, 1);
    check("fetch_pcwrite", pcwrite, 1);
    check("fetch_alusrcb", alusrcb, 2'b10);
    check("fetch_resultsrc", resultsrc, 2'b10);
    chk_ret("ret_init", 0);

    // ADD R1,R2,#5
    tick(); check("add_s1", state, 1); check("add_dec_pcwrite", pcwrite, 0);
    check("add_dec_illegal", illegal, 0);
    tick(); check("add_s7", state, 7); check("add_alusrcb", alusrcb, 2'b01);
    check("add_aluctl", alucontrol, 2'b00); check("add_execi_regwrite", regwrite, 0);
    tick(); check("add_s8", state, 8); check("add_wb_regwrite", regwrite, 1);
    check("add_wb_pcwrite", pcwrite, 0);
    tick(); check("add_s0", state, 0); chk_ret("ret_add", 1);

    // LDR PC,[..]
    set_ir(4'b1110, 2'b01, 6'b011001, 4'd15);
    tick(); check("ldr_s1", state, 1);
    tick(); check("ldr_s2", state, 2); check("ldr_immsrc", immsrc, 2'b01);
    check("ldr_regsrc", regsrc, 2'b10);
    tick(); check("ldr_s3", state, 3); check("ldr_adrsrc", adrsrc, 1);
    tick(); check("ldr_s4", state, 4); check("ldr_pcwrite", pcwrite, 1);
    check("ldr_regwrite", regwrite, 0); check("ldr_resultsrc", resultsrc, 2'b01);
    tick(); check("ldr_s0", state, 0); chk_ret("ret_ldr", 2);

    // STR R3,[..]
    set_ir(4'b1110, 2'b01, 6'b011000, 4'd3);
    tick(); check("str_s1", state, 1);
    tick(); check("str_s2", state, 2); check("str_mw_adr", memwrite, 0);
    tick(); check("str_s5", state, 5); check("str_memwrite", memwrite, 1);
    check("str_regsrc", regsrc, 2'b10); check("str_adrsrc", adrsrc, 1);
    tick(); check("str_s0", state, 0); check("str_mw_after", memwrite, 0);
    chk_ret("ret_str", 3);

    // SUBS R1,R1,R2 with ALU NZCV=0110
    set_ir(4'b1110, 2'b00, 6'b000101, 4'd1);
    alu_flags = 4'b0110;
    tick(); check("subs_s1", state, 1);
    tick(); check("subs_s6", state, 6); check("subs_aluctl", alucontrol, 2'b01);
    check("subs_flags_pre", flags, 4'b0000);
    tick(); check("subs_s8", state, 8); check("subs_flags", flags, 4'b0110);
    tick(); chk_ret("ret_subs", 4);

    // BEQ taken (Z=1)
    set_ir(4'b0000, 2'b10, 6'b000000, 4'd0);
    tick(); check("beq_s1", state, 1);
    tick(); check("beq_s9", state, 9); check("beq_pcwrite", pcwrite, 1);
    check("beq_regsrc", regsrc, 2'b01); check("beq_immsrc", immsrc, 2'b10);
    check("beq_alusrca", alusrca, 0);
    tick(); check("beq_s0", state, 0); chk_ret("ret_beq", 5);

    // BNE not taken
    set_ir(4'b0001, 2'b10, 6'b000000, 4'd0);
    tick(); check("bne_s1", state, 1);
    tick(); check("bne_s0", state, 0); chk_ret("ret_bne", 5);

    // op=11 illegal
    set_ir(4'b1110, 2'b11, 6'b000000, 4'd0);
    tick(); check("ill_op_pulse", illegal, 1);
    tick(); check("ill_op_s0", state, 0); check("ill_op_clear", illegal, 0);
    chk_ret("ret_ill", 5);

    // cond=1111 illegal
    set_ir(4'b1111, 2'b00, 6'b001000, 4'd0);
    tick(); check("ill_cond_pulse", illegal, 1);
    tick(); check("ill_cond_s0", state, 0);

    // CMP with ALU NZCV=1000
    set_ir(4'b1110, 2'b00, 6'b010101, 4'd0);
    alu_flags = 4'b1000;
    tick();
    tick(); check("cmp_s6", state, 6); check("cmp_aluctl", alucontrol, 2'b01);
    tick(); check("cmp_s0", state, 0); check("cmp_flags", flags, 4'b1000);
    chk_ret("ret_cmp", 6);

    // ADDS imm with ALU NZCV=0011
    set_ir(4'b1110, 2'b00, 6'b101001, 4'd2);
    alu_flags = 4'b0011;
    tick(); tick(); tick();
    check("adds_flags", flags, 4'b0011);
    tick();

    // ANDS imm with ALU NZCV=0100: C,V retained
    set_ir(4'b1110, 2'b00, 6'b100001, 4'd2);
    alu_flags = 4'b0100;
    tick();
    tick(); check("ands_aluctl", alucontrol, 2'b10);
    tick(); check("ands_flags", flags, 4'b0111);
    tick(); chk_ret("ret_ands", 8);

    // BLT: N=0,V=1 -> taken
    set_ir(4'b1011, 2'b10, 6'b000000, 4'd0);
    tick();
    tick(); check("blt_s9", state, 9);
    tick(); chk_ret("ret_blt", 9);

    // Reset mid-EXECR of an ADDS: flags must not absorb ALU 1111
    set_ir(4'b1110, 2'b00, 6'b001001, 4'd4);
    alu_flags = 4'b1111;
    tick();
    tick(); check("rmid_s6", state, 6);
    rst = 1'b0;
    tick(); check("rmid_state", state, 0); check("rmid_flags", flags, 4'b0000);
    check("rmid_irwrite", irwrite, 0); check("rmid_pcwrite", pcwrite, 0);
    check("rmid_regwrite", regwrite, 0);
    tick(); check("rmid_state2", state, 0); check("rmid_pcwrite2", pcwrite, 0);
    chk_ret("ret_rst", 0);
    rst = 1'b1;
    #1;
    check("rmid_release_irwrite", irwrite, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
